transfer_sequencer: RTL
=======================

TRANSFER_SEQUENCER -- requirements
Module: transfer_sequencer

Interface
REQ-001 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-003 SHALL have port start_cmd  input  1  one-cycle pulse; driver command-register write requesting a data transfer.
REQ-004 SHALL have port block_size  input  12  bytes per block (block_size_register[11:0]).
REQ-005 SHALL have port block_count  input  16  blocks to transfer (block_count_register).
REQ-006 SHALL have ports multi_block (transfer_mode[5]) and count_enable (transfer_mode[1])  input  1 each.
REQ-007 SHALL have ports stop_at_gap_req (block_gap_control[0]) and continue_req (block_gap_control[1])  input  1 each.
REQ-008 SHALL have port word_done  input  1  one 32-bit word moved by the dma datapath this cycle (fifo_read | fifo_write).
REQ-009 SHALL have port abort  input  1  software abort of the current transfer.
REQ-010 SHALL have port dma_start  output  1  one-cycle pulse to the dma start_flag.
REQ-011 SHALL have port dma_stop  output  1  level; holds the dma datapath stopped.
REQ-012 SHALL have ports busy  output  1  transfer in progress; blocks_remaining  output  16  current block counter.
REQ-013 SHALL have ports transfer_complete and block_gap_event  output  1 each  one-cycle pulses.
REQ-014 SHALL have port error_status  output  4  [0] zero block_size, [1] zero block_count with count_enable, [2] block_size>2048, [3] spurious word_done.

Function
REQ-015 SHALL implement states IDLE, START, XFER, GAP, DONE.
REQ-016 SHALL compute words_per_block = (block_size+3)>>2, 11 bits, at start_cmd acceptance.
REQ-017 IDLE: on start_cmd, SHALL evaluate error bits [2:0]; on any set -> latch them, stay IDLE, no dma_start.
REQ-018 IDLE: on start_cmd with no config error SHALL clear error_status, load word counter = words_per_block, go to START.
REQ-019 Block counter load SHALL be: block_count if multi_block&count_enable; 0 (unlimited) if multi_block&~count_enable; 1 if ~multi_block.
REQ-020 START: SHALL assert dma_start for exactly one cycle, then go to XFER.
REQ-021 XFER: each word_done SHALL decrement the word counter by 1.
REQ-022 XFER: word_done with word counter==1 ends a block; blocks_remaining SHALL decrement unless in unlimited mode.
REQ-023 End of block with blocks_remaining==1 (counted mode) SHALL go to DONE.
REQ-024 Otherwise end of block with stop_at_gap_req=1 SHALL go to GAP and pulse block_gap_event in the cycle GAP is entered.
REQ-025 Otherwise end of block SHALL reload the word counter and remain in XFER with no bubble.
REQ-026 GAP: continue_req=1 SHALL reload the word counter and go to START; continue_req ignored in other states.
REQ-027 DONE: transfer_complete SHALL pulse one cycle, then IDLE.
REQ-028 dma_stop SHALL be 1 in IDLE, GAP, DONE and 0 in START, XFER; busy SHALL be 0 only in IDLE.
REQ-029 abort in any non-IDLE state SHALL go to IDLE next cycle, clear counters, suppress transfer_complete; abort has priority over word_done and continue_req.
REQ-030 start_cmd while busy SHALL be ignored.
REQ-031 word_done outside XFER SHALL set error_status[3] (sticky until next accepted start_cmd); counters unchanged.

Reset
REQ-032 RESET=1 at a clock edge SHALL force IDLE, counters 0, error_status 0, dma_start 0, dma_stop 1, busy 0, pulses 0, overriding all other inputs, including mid-transfer.

Verification
REQ-033 block_size=512, block_count=2, multi_block=1, count_enable=1, start_cmd -> dma_start next cycle; blocks_remaining 2->1->0 after word_done #128/#256; transfer_complete one cycle after #256; busy=0 after.
REQ-034 block_size=6, multi_block=0, start_cmd -> words_per_block=2; DONE after 2 word_done; transfer_complete single pulse.
REQ-035 block_size=512, block_count=3, stop_at_gap_req=1 during block 1 -> after word_done #128: GAP, dma_stop=1, block_gap_event pulse, blocks_remaining=2; continue_req -> dma_start pulse, XFER.
REQ-036 block_size=0, start_cmd -> error_status=4'b0001, busy=0, no dma_start; block_size=3000 -> 4'b0100.
REQ-037 RESET asserted after word_done #50 of block 1 -> next edge all outputs at reset values; following start_cmd behaves as fresh transfer.
REQ-038 abort and word_done same cycle in XFER -> IDLE next cycle, blocks_remaining=0, no transfer_complete; word_done thereafter sets error_status[3].

Source files
------------

// File: rtl/transfer_sequencer.sv
// -----------------------------------------------------------------------------
// transfer_sequencer
// Sequences a block-oriented DMA transfer. It accepts a start command, checks
// the block configuration, then counts 32-bit words into blocks and blocks
// into a transfer. Between blocks it can optionally park in a block gap.
//
// Ports
//   CLK, RESET           clock; synchronous active-high reset
//   start_cmd            one-cycle command-register write requesting a transfer
//   block_size[11:0]     bytes per block
//   block_count[15:0]    blocks to transfer (counted multi-block mode)
//   multi_block          transfer_mode[5]
//   count_enable         transfer_mode[1]
//   stop_at_gap_req      block_gap_control[0]: park at the next block end
//   continue_req         block_gap_control[1]: resume from a block gap
//   word_done            one 32-bit word moved by the DMA datapath this cycle
//   abort                software abort of the current transfer
//   dma_start            one-cycle pulse to the DMA start flag
//   dma_stop             level; holds the DMA datapath stopped
//   busy                 transfer in progress
//   blocks_remaining     current block counter
//   transfer_complete    one-cycle pulse at the end of the transfer
//   block_gap_event      one-cycle pulse on entering the block gap
//   error_status[3:0]    [0] zero size, [1] zero count, [2] size>2048,
//                        [3] word_done outside XFER (sticky)
// -----------------------------------------------------------------------------
module transfer_sequencer (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        start_cmd,
   input  logic [11:0] block_size,
   input  logic [15:0] block_count,
   input  logic        multi_block,
   input  logic        count_enable,
   input  logic        stop_at_gap_req,
   input  logic        continue_req,
   input  logic        word_done,
   input  logic        abort,
   output logic        dma_start,
   output logic        dma_stop,
   output logic        busy,
   output logic [15:0] blocks_remaining,
   output logic        transfer_complete,
   output logic        block_gap_event,
   output logic [3:0]  error_status
);

   typedef enum logic [2:0] {IDLE, START, XFER, GAP, DONE} state_t;

   state_t      state;
   logic [10:0] word_cnt;
   logic [10:0] wpb_q;       // words per block, held for reloads at block ends
   logic        counted;     // 0 = unlimited multi-block mode

   logic [12:0] bs_plus3;
   logic [10:0] words_per_block;
   logic [2:0]  cfg_err;
   logic        spurious;
   logic        end_of_block;

   // Round the byte count up to whole 32-bit words.
   assign bs_plus3        = {1'b0, block_size} + 13'd3;
   assign words_per_block = bs_plus3[12:2];

   assign cfg_err[0] = (block_size == 12'd0);
   assign cfg_err[1] = count_enable && (block_count == 16'd0);
   assign cfg_err[2] = (block_size > 12'd2048);

   assign spurious     = word_done && (state != XFER);
   assign end_of_block = word_done && (word_cnt == 11'd1);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state             <= IDLE;
         word_cnt          <= '0;
         wpb_q             <= '0;
         counted           <= 1'b0;
         blocks_remaining  <= '0;
         error_status      <= '0;
         dma_start         <= 1'b0;
         dma_stop          <= 1'b1;
         busy              <= 1'b0;
         transfer_complete <= 1'b0;
         block_gap_event   <= 1'b0;
      end else begin
         dma_start         <= 1'b0;
         transfer_complete <= 1'b0;
         block_gap_event   <= 1'b0;

         if (spurious)
            error_status[3] <= 1'b1;

         if (state != IDLE && abort) begin
            // Abort outranks word_done/continue_req; no completion pulse.
            state            <= IDLE;
            word_cnt         <= '0;
            blocks_remaining <= '0;
            dma_stop         <= 1'b1;
            busy             <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start_cmd) begin
                     if (|cfg_err) begin
                        error_status <= {error_status[3] | spurious, cfg_err};
                     end else begin
                        error_status <= {spurious, 3'b000};
                        wpb_q        <= words_per_block;
                        word_cnt     <= words_per_block;
                        counted      <= !multi_block || count_enable;
                        if (!multi_block)
                           blocks_remaining <= 16'd1;
                        else if (count_enable)
                           blocks_remaining <= block_count;
                        else
                           blocks_remaining <= 16'd0;
                        state     <= START;
                        dma_start <= 1'b1;
                        dma_stop  <= 1'b0;
                        busy      <= 1'b1;
                     end
                  end
               end
               START: state <= XFER;
               XFER: begin
                  if (end_of_block) begin
                     if (counted)
                        blocks_remaining <= blocks_remaining - 16'd1;
                     if (counted && blocks_remaining == 16'd1) begin
                        state             <= DONE;
                        word_cnt          <= '0;
                        transfer_complete <= 1'b1;
                        dma_stop          <= 1'b1;
                     end else if (stop_at_gap_req) begin
                        state           <= GAP;
                        word_cnt        <= '0;
                        block_gap_event <= 1'b1;
                        dma_stop        <= 1'b1;
                     end else begin
                        word_cnt <= wpb_q;   // back-to-back blocks, no bubble
                     end
                  end else if (word_done) begin
                     word_cnt <= word_cnt - 11'd1;
                  end
               end
               GAP: begin
                  if (continue_req) begin
                     word_cnt  <= wpb_q;
                     state     <= START;
                     dma_start <= 1'b1;
                     dma_stop  <= 1'b0;
                  end
               end
               DONE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
